con_port_arbiter: RTL

// - Shares the core's single data-memory controller port (con_addr/con_write/con_in/con_out)

---
 rtl/con_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/con_port_arbiter.sv
// Two-master round-robin arbiter in front of the core's single data-memory controller port.
// Define CON_ARB_FIXED_PRIO_EN for strict priority (m0 wins every tie).
//
// state   | meaning
// --------+--------------------------------------------------------------
// S_IDLE  | no transaction; grant a pending request and latch its fields
// S_ISSUE | drive latched addr/we/wdata to the core for one cycle
// S_WAIT  | read in flight; hold address, count down RD_LAT, capture data
module con_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic              CLK,
  input  logic              nrst,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_we,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_we,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [ADDR_W-1:0] con_addr,
  output logic [3:0]        con_write,
  output logic [DATA_W-1:0] con_in,
  input  logic [DATA_W-1:0] con_out,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        we_q, we_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              id_q, id_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rvalid0_q, rvalid0_d;
  logic              rvalid1_q, rvalid1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              win1;

`ifdef CON_ARB_FIXED_PRIO_EN
  assign win1 = ~m0_req;
`else
  logic last_q, last_d;

  // last_q=1 means m1 was granted last, so m0 wins the next tie
  assign win1   = m1_req & (~m0_req | ~last_q);
  assign last_d = (m0_gnt | m1_gnt) ? m1_gnt : last_q;

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) last_q <= 1'b1;
    else       last_q <= last_d;
  end
`endif

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    id_d      = id_q;
    cnt_d     = cnt_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    con_addr  = '0;
    con_write = 4'h0;
    con_in    = '0;

    case (state_q)
      S_IDLE: begin
        // gnt is gated by nrst so nothing is accepted while reset is held
        if (nrst && (m0_req || m1_req)) begin
          m0_gnt  = ~win1;
          m1_gnt  = win1;
          addr_d  = win1 ? m1_addr  : m0_addr;
          we_d    = win1 ? m1_we    : m0_we;
          wdata_d = win1 ? m1_wdata : m0_wdata;
          id_d    = win1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        con_addr  = addr_q;
        con_write = we_q;
        con_in    = wdata_q;
        if (we_q == 4'h0) begin
          cnt_d   = CNT_LOAD;
          state_d = S_WAIT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        con_addr = addr_q;
        if (cnt_q == '0) begin
          if (id_q) begin
            rdata1_d  = con_out;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = con_out;
            rvalid0_d = 1'b1;
          end
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nrst) begin
    if (!nrst) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      we_q      <= 4'h0;
      wdata_q   <= '0;
      id_q      <= 1'b0;
      cnt_q     <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
    end
  end

  assign m0_rvalid = rvalid0_q;
  assign m1_rvalid = rvalid1_q;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign busy      = (state_q != S_IDLE);

endmodule
